// File: rtl/imem_boot_loader.sv
// Boot loader: receives a little-endian byte stream, packs it into 32-bit words,
// writes them to instruction memory and releases the CPU reset once the image is loaded.
module imem_boot_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           len_words,
  input  logic                  abort,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // Byte handshake: a byte transfers on a rising edge where rx_valid and rx_ready
  // are both 1; rx_ready is a pure function of state, never of rx_valid.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [16:0] MEM_SIZE_W = 17'(MEM_SIZE);

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           word_idx_q, word_idx_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           asm_q, asm_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [15:0]           word_idx_inc;

  assign word_idx_inc = word_idx_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    err_d       = err_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if ({1'b0, len_words} > MEM_SIZE_W) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b1;
          end else if (len_words == 16'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b0;
          end else begin
            state_d    = ST_RECV;
            len_d      = len_words;
            word_idx_d = 16'd0;
            byte_cnt_d = 2'd0;
            done_d     = 1'b0;
            err_d      = 1'b0;
          end
        end
      end

      ST_RECV: begin
        if (abort) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          byte_cnt_d = 2'd0;
        end else if (rx_valid) begin
          // Bytes shift in from the top so byte 0 ends up in the low lane.
          if (byte_cnt_q == 2'd3) begin
            state_d     = ST_WRITE;
            byte_cnt_d  = 2'd0;
            mem_wdata_d = DATA_WIDTH'({rx_data, asm_q});
            mem_addr_d  = ADDR_WIDTH'({word_idx_q, 2'b00});
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            asm_d      = {rx_data, asm_q[23:8]};
          end
        end
      end

      ST_WRITE: begin
        if (abort) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          byte_cnt_d = 2'd0;
        end else begin
          word_idx_d = word_idx_inc;
          byte_cnt_d = 2'd0;
          if (word_idx_inc == len_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RECV;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // An abort landing in WRITE suppresses the strobe in that same cycle.
  assign rx_ready  = (state_q == ST_RECV);
  assign busy      = (state_q == ST_RECV) || (state_q == ST_WRITE);
  assign mem_we    = (state_q == ST_WRITE) && !abort;
  assign cpu_rst_n = (state_q == ST_DONE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed and randomized checks of imem_boot_loader against a word-packing
// reference model (expected memory writes computed from the byte stream).
module tb_imem_boot_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] len_words;
  logic        abort;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  imem_boot_loader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .MEM_SIZE  (512)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len_words(len_words),
    .abort    (abort),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int first_acc = 0;

  logic [7:0]  bytes_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int          ready_in_write = 0;

  // ---------------- write monitor ----------------
  always @(negedge clk) begin
    if (mem_we) begin
      obs_q.push_back({mem_addr, mem_wdata});
      if (rx_ready) ready_in_write++;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Reference model: word w of the image is bytes 4w..4w+3, little-endian, at byte address 4w.
  task automatic build_exp(input int n_words);
    logic [31:0] w_data;
    for (int w = 0; w < n_words; w++) begin
      w_data = {bytes_q[4*w+3], bytes_q[4*w+2], bytes_q[4*w+1], bytes_q[4*w]};
      exp_q.push_back({32'(w * 4), w_data});
    end
  endtask

  task automatic compare_writes(input string tag);
    logic [63:0] o;
    logic [63:0] e;
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_write"}, o, e);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input int len);
    start     = 1'b1;
    len_words = 16'(len);
    tick();
    start     = 1'b0;
  endtask

  // mode 0: always valid, 1: alternate valid every cycle, 2: random valid
  task automatic feed(input int n, input int mode);
    int sent = 0;
    int guard = 0;
    bit tog = 1'b1;
    bit v;
    while (sent < n && guard < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      rx_data  = (bytes_q.size() > 0) ? bytes_q[0] : 8'h00;
      rx_valid = v;
      if (v && rx_ready) begin
        if (sent == 0) first_acc = cyc;
        sent++;
        void'(bytes_q.pop_front());
      end
      tick();
      guard++;
    end
    rx_valid = 1'b0;
    check("feed_bytes_accepted", 64'(sent), 64'(n));
  endtask

  task automatic wait_done(input int limit);
    int g = 0;
    while (!done && g < limit) begin
      tick();
      g++;
    end
  endtask

  // ---------------- stimulus ----------------
  int          len;
  int          mode;
  logic [7:0]  img[8];

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len_words = '0;
    abort     = 1'b0;
    rx_data   = '0;
    rx_valid  = 1'b0;

    #2;
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_err",       64'(err),       64'd0);
    check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("rst_rx_ready",  64'(rx_ready),  64'd0);
    check("rst_mem_we",    64'(mem_we),    64'd0);
    check("rst_mem_addr",  64'(mem_addr),  64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_after_rst_busy", 64'(busy), 64'd0);

    // Directed two-word image with timing of done.
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    foreach (img[i]) bytes_q.push_back(img[i]);
    build_exp(2);
    do_start(2);
    check("load_busy", 64'(busy), 64'd1);
    feed(8, 0);
    wait_done(20);
    check("load_done_latency", 64'(cyc - first_acc), 64'd10);
    check("load_done",      64'(done),      64'd1);
    check("load_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
    check("load_err",       64'(err),       64'd0);
    compare_writes("load");
    check("load_ready_in_write", 64'(ready_in_write), 64'd0);

    // Oversized length is rejected.
    do_start(513);
    tick();
    check("bad_len_err",       64'(err),       64'd1);
    check("bad_len_busy",      64'(busy),      64'd0);
    check("bad_len_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("bad_len_done",      64'(done),      64'd0);
    compare_writes("bad_len");

    // Zero length completes immediately without writes.
    do_start(0);
    check("zero_len_done",      64'(done),      64'd1);
    check("zero_len_err",       64'(err),       64'd0);
    check("zero_len_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
    tick();
    compare_writes("zero_len");

    // Reload from DONE, ignored start while busy, throttled source.
    for (int i = 0; i < 4; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
    build_exp(1);
    do_start(1);
    check("reload_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("reload_busy",      64'(busy),      64'd1);
    do_start(5);
    check("busy_start_ignored", 64'(busy), 64'd1);
    feed(4, 1);
    wait_done(10);
    check("throttle_done", 64'(done), 64'd1);
    compare_writes("throttle");
    check("throttle_ready_in_write", 64'(ready_in_write), 64'd0);

    // Abort two bytes into word 1, with a byte offered in the same cycle.
    for (int i = 0; i < 12; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
    build_exp(1);
    do_start(3);
    feed(6, 0);
    abort    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    tick();
    abort    = 1'b0;
    rx_valid = 1'b0;
    check("abort_err",       64'(err),       64'd1);
    check("abort_busy",      64'(busy),      64'd0);
    check("abort_rx_ready",  64'(rx_ready),  64'd0);
    check("abort_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    tick();
    tick();
    compare_writes("abort");
    bytes_q.delete();

    // Randomized images and source throttling.
    for (int r = 0; r < 8; r++) begin
      len  = $urandom_range(1, 5);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 4 * len; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
      build_exp(len);
      do_start(len);
      feed(4 * len, mode);
      wait_done(10);
      check("rand_done", 64'(done), 64'd1);
      check("rand_err",  64'(err),  64'd0);
      compare_writes("rand");
    end
    check("rand_ready_in_write", 64'(ready_in_write), 64'd0);

    // Asynchronous reset in the middle of a word.
    for (int i = 0; i < 8; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
    do_start(2);
    feed(3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",      64'(busy),      64'd0);
    check("mid_rst_rx_ready",  64'(rx_ready),  64'd0);
    check("mid_rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("mid_rst_done",      64'(done),      64'd0);
    check("mid_rst_err",       64'(err),       64'd0);
    check("mid_rst_mem_addr",  64'(mem_addr),  64'd0);
    check("mid_rst_mem_wdata", 64'(mem_wdata), 64'd0);
    tick();
    rst_n = 1'b1;
    rx_valid = 1'b1;
    tick();
    tick();
    tick();
    rx_valid = 1'b0;
    check("post_rst_idle_busy", 64'(busy), 64'd0);
    bytes_q.delete();
    compare_writes("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
